mac_sequencer: RTL and testbench

Sequences the 4-tap multiply-accumulate datapath: accepts one input sample per valid/ready handshake, steps the tap-select mux through every tap, then latches the accumulated result into the output register. Presents the result downstream on a valid/ready handshake with backpressure. Supersedes the free-running four-state tap controller, so the datapath only runs when a sample is present and a result slot is free.

---
 rtl/mac_sequencer_pkg.sv | 12 +
 rtl/mac_tap_counter.sv | 29 ++
 rtl/mac_sequencer.sv | 100 ++++++++++
 tb/tb_mac_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared types and defaults for the 4-tap MAC sequencer.
package mac_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LATCH = 2'b10
  } mac_seq_state_t;

  localparam int MAC_NTAPS = 4;

endpackage

// File: rtl/mac_tap_counter.sv
// Tap index counter: walks 0..NTAPS-1 while inc is high and flags the final tap.
module mac_tap_counter #(
  parameter int NTAPS = 4,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  output logic [SELW-1:0] tap,
  output logic            last
);

  localparam logic [SELW-1:0] LAST_TAP = SELW'(NTAPS - 1);

  logic [SELW-1:0] tap_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tap_reg <= '0;
    end else if (inc) begin
      tap_reg <= (tap_reg == LAST_TAP) ? '0 : tap_reg + SELW'(1);
    end
  end

  assign tap  = tap_reg;
  assign last = (tap_reg == LAST_TAP);

endmodule

// File: rtl/mac_sequencer.sv
// MAC datapath sequencer: accepts a sample, runs every tap once, then latches the
// result into the output register when the downstream slot is free.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int NTAPS = MAC_NTAPS,
  parameter int SELW  = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            loadSample,
  output logic [SELW-1:0] muxControl,
  output logic            accumEn,
  output logic            clearAccum,
  output logic            enData,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [CNTW-1:0] sample_count
);

  mac_seq_state_t  state_reg;
  logic            out_valid_reg;
  logic [CNTW-1:0] sample_count_reg;
  logic [SELW-1:0] tap;
  logic            tap_last;
  logic            in_run;

  assign in_run = (state_reg == S_RUN);

  mac_tap_counter #(
    .NTAPS(NTAPS),
    .SELW (SELW)
  ) u_tap_counter (
    .clk  (clk),
    .reset(reset),
    .clear(!in_run),
    .inc  (in_run),
    .tap  (tap),
    .last (tap_last)
  );

  // Strobes are forced low while reset is held so a sample in flight is abandoned cleanly.
  always_comb begin
    in_ready   = 1'b0;
    loadSample = 1'b0;
    muxControl = '0;
    accumEn    = 1'b0;
    clearAccum = 1'b0;
    enData     = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_IDLE: begin
          in_ready   = 1'b1;
          loadSample = in_valid;
        end
        S_RUN: begin
          muxControl = tap;
          accumEn    = 1'b1;
          clearAccum = (tap == '0);
        end
        S_LATCH: begin
          enData = !out_valid_reg || out_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      out_valid_reg    <= 1'b0;
      sample_count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE:  if (in_valid) state_reg <= S_RUN;
        S_RUN:   if (tap_last) state_reg <= S_LATCH;
        S_LATCH: if (enData) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase

      // A fresh result replaces one being consumed in the same cycle, so no bubble.
      if (enData) begin
        out_valid_reg    <= 1'b1;
        sample_count_reg <= sample_count_reg + CNTW'(1);
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign sample_count = sample_count_reg;
  assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two configurations share stimulus and are checked each cycle
// against a sample-age reference model, plus literal checks of the key timing points.
module tb_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, out_ready;
  logic ir[2], ld[2], ae[2], ca[2], ed[2], ov[2], bz[2];
  logic [1:0] mux[2];
  logic [15:0] sc_a;
  logic [1:0]  sc_b;

  mac_sequencer #(.NTAPS(4), .SELW(2), .CNTW(16)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .loadSample(ld[0]), .muxControl(mux[0]), .accumEn(ae[0]), .clearAccum(ca[0]),
    .enData(ed[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]),
    .sample_count(sc_a)
  );

  mac_sequencer #(.NTAPS(3), .SELW(2), .CNTW(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .loadSample(ld[1]), .muxControl(mux[1]), .accumEn(ae[1]), .clearAccum(ca[1]),
    .enData(ed[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]),
    .sample_count(sc_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: a sample is "active" from acceptance until its result is latched; age counts
  // cycles since acceptance, so ages 1..N are the tap cycles and later ages wait to latch.
  int m_active[2] = '{0, 0};
  int m_age[2]    = '{0, 0};
  int m_ov[2]     = '{0, 0};
  int m_cnt[2]    = '{0, 0};
  int ntaps[2]    = '{4, 3};
  int modulo[2]   = '{65536, 4};

  always @(negedge clk) begin : compare
    bit e_ir, e_ld, e_ae, e_ca, e_ed;
    int e_mux, got_cnt, was_active;
    logic [9:0] e_vec, g_vec;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        e_ir = 0; e_ld = 0; e_ae = 0; e_ca = 0; e_ed = 0; e_mux = 0;
        if (!reset) begin
          if (m_active[i] == 0) begin
            e_ir = 1;
            e_ld = in_valid;
          end else if (m_age[i] <= ntaps[i]) begin
            e_mux = m_age[i] - 1;
            e_ae  = 1;
            e_ca  = (m_age[i] == 1);
          end else begin
            e_ed = (m_ov[i] == 0) || out_ready;
          end
        end
        e_vec = {e_ir, e_ld, 2'(e_mux), e_ae, e_ca, e_ed, m_ov[i] != 0, m_active[i] != 0};
        g_vec = {ir[i], ld[i], mux[i], ae[i], ca[i], ed[i], ov[i], bz[i]};
        got_cnt = (i == 0) ? int'(sc_a) : int'(sc_b);
        vectors++;
        if (e_vec !== g_vec || got_cnt != m_cnt[i]) begin
          miscompares++;
          $display("FAIL model cyc%0d inst%0d: got {ir,ld,mux,ae,ca,ed,ov,busy}=%b cnt=%0d, want %b cnt=%0d",
                   cyc, i, g_vec, got_cnt, e_vec, m_cnt[i]);
        end
        // Advance the model to what must hold after the coming rising edge.
        if (reset) begin
          m_active[i] = 0; m_age[i] = 0; m_ov[i] = 0; m_cnt[i] = 0;
        end else begin
          was_active = m_active[i];
          if (e_ed) begin
            m_ov[i]     = 1;
            m_cnt[i]    = (m_cnt[i] + 1) % modulo[i];
            m_active[i] = 0;
          end else if (out_ready) begin
            m_ov[i] = 0;
          end
          if (was_active == 0 && in_valid) begin
            m_active[i] = 1;
            m_age[i]    = 1;
          end else if (was_active != 0 && m_age[i] <= ntaps[i]) begin
            m_age[i]++;
          end
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  int prob;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    lit("rst_in_ready_a", int'(ir[0]), 1);
    lit("rst_in_ready_b", int'(ir[1]), 1);
    lit("rst_out_valid", int'(ov[0]), 0);
    lit("rst_count", int'(sc_a), 0);
    lit("rst_busy", int'(bz[0]), 0);

    // Single sample with downstream always ready.
    step(); in_valid = 1'b1;
    @(negedge clk); lit("c0_loadSample", int'(ld[0]), 1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    lit("c1_mux", int'(mux[0]), 0);
    lit("c1_accumEn", int'(ae[0]), 1);
    lit("c1_clearAccum", int'(ca[0]), 1);
    for (int c = 2; c <= 4; c++) begin
      step();
      @(negedge clk);
      lit("run_mux", int'(mux[0]), c - 1);
      lit("run_clearAccum", int'(ca[0]), 0);
    end
    step(); @(negedge clk); lit("c5_enData", int'(ed[0]), 1);
    step(); @(negedge clk); lit("c6_out_valid", int'(ov[0]), 1);
    step(); @(negedge clk);
    lit("c7_out_valid", int'(ov[0]), 0);
    lit("c7_count", int'(sc_a), 1);

    // Reset while the sequencer is on tap 2.
    step(); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step();
    step(); reset = 1'b1;
    @(negedge clk);
    lit("rst_run_mux", int'(mux[0]), 0);
    lit("rst_run_accumEn", int'(ae[0]), 0);
    step(); reset = 1'b0;
    @(negedge clk);
    lit("post_rst_busy", int'(bz[0]), 0);
    lit("post_rst_enData", int'(ed[0]), 0);
    lit("post_rst_out_valid", int'(ov[0]), 0);
    lit("post_rst_count", int'(sc_a), 0);

    // Randomized traffic with varying downstream backpressure.
    prob = 50;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n % 200 == 0) prob = (n / 200) % 3 == 0 ? 10 : ((n / 200) % 3 == 1 ? 50 : 95);
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 99) < prob);
    end
    step();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
